// File: rtl/clock_rtc_ctrl.sv
// Real-time clock: prescaled one-second tick, HH:MM:SS with day counter,
// valid/ready time-set port with range check, 12/24h display and HH:MM alarm.
module clock_rtc_ctrl #(
    parameter int P_COUNT_BIT = 30,
    parameter int P_SEC_BIT   = 6,
    parameter int P_MIN_BIT   = 6,
    parameter int P_HOUR_BIT  = 5,
    parameter int P_DAY_BIT   = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   en,
    input  logic [P_COUNT_BIT-1:0] i_freq,
    input  logic                   i_mode_12h,
    input  logic                   i_set_valid,
    output logic                   o_set_ready,
    input  logic [P_SEC_BIT-1:0]   i_set_sec,
    input  logic [P_MIN_BIT-1:0]   i_set_min,
    input  logic [P_HOUR_BIT-1:0]  i_set_hour,
    output logic                   o_set_err,
    input  logic                   i_alarm_en,
    input  logic [P_MIN_BIT-1:0]   i_alarm_min,
    input  logic [P_HOUR_BIT-1:0]  i_alarm_hour,
    output logic [P_SEC_BIT-1:0]   sec,
    output logic [P_MIN_BIT-1:0]   min,
    output logic [P_HOUR_BIT-1:0]  hour,
    output logic                   o_pm,
    output logic [P_DAY_BIT-1:0]   o_day,
    output logic                   o_sec_tick,
    output logic                   o_alarm
);

    localparam logic [0:0] S_IDLE  = 1'b0;
    localparam logic [0:0] S_APPLY = 1'b1;

    localparam logic [P_SEC_BIT-1:0]  SEC_LAST  = P_SEC_BIT'(59);
    localparam logic [P_MIN_BIT-1:0]  MIN_LAST  = P_MIN_BIT'(59);
    localparam logic [P_HOUR_BIT-1:0] HOUR_LAST = P_HOUR_BIT'(23);
    localparam logic [P_HOUR_BIT-1:0] HOUR_NOON = P_HOUR_BIT'(12);

    logic [0:0]             state;
    logic [P_COUNT_BIT-1:0] cnt;
    logic [P_COUNT_BIT-1:0] cnt_last;
    logic [P_HOUR_BIT-1:0]  hour_q;
    logic                   tick;
    logic                   set_acc;
    logic                   set_ok;
    logic [P_SEC_BIT-1:0]   sec_nx;
    logic [P_MIN_BIT-1:0]   min_nx;
    logic [P_HOUR_BIT-1:0]  hour_nx;
    logic                   day_inc;

    // >= rather than == so a lowered i_freq cannot strand cnt above the limit
    assign cnt_last = (i_freq <= P_COUNT_BIT'(1)) ? '0
                    : i_freq - P_COUNT_BIT'(1);
    assign tick     = en & (cnt >= cnt_last);

    assign o_set_ready = (state == S_IDLE) & ~reset;
    assign set_acc     = i_set_valid & o_set_ready;
    assign set_ok      = (i_set_sec <= SEC_LAST)
                       & (i_set_min <= MIN_LAST)
                       & (i_set_hour <= HOUR_LAST);

    always_comb begin
        sec_nx  = sec + P_SEC_BIT'(1);
        min_nx  = min;
        hour_nx = hour_q;
        day_inc = 1'b0;
        if (sec == SEC_LAST) begin
            sec_nx = '0;
            min_nx = min + P_MIN_BIT'(1);
            if (min == MIN_LAST) begin
                min_nx  = '0;
                hour_nx = hour_q + P_HOUR_BIT'(1);
                if (hour_q == HOUR_LAST) begin
                    hour_nx = '0;
                    day_inc = 1'b1;
                end
            end
        end
    end

    always_comb begin
        hour = hour_q;
        if (i_mode_12h) begin
            if (hour_q == '0)
                hour = HOUR_NOON;
            else if (hour_q > HOUR_NOON)
                hour = hour_q - HOUR_NOON;
        end
    end

    assign o_pm = (hour_q >= HOUR_NOON);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= S_IDLE;
            cnt        <= '0;
            sec        <= '0;
            min        <= '0;
            hour_q     <= '0;
            o_day      <= '0;
            o_sec_tick <= 1'b0;
            o_set_err  <= 1'b0;
            o_alarm    <= 1'b0;
        end else begin
            o_sec_tick <= 1'b0;
            o_alarm    <= 1'b0;
            o_set_err  <= set_acc & ~set_ok;
            state      <= set_acc ? S_APPLY : S_IDLE;
            if (en)
                cnt <= tick ? '0 : cnt + P_COUNT_BIT'(1);
            // a valid load overrides any coincident tick
            if (set_acc && set_ok) begin
                sec    <= i_set_sec;
                min    <= i_set_min;
                hour_q <= i_set_hour;
                cnt    <= '0;
            end else if (tick) begin
                sec        <= sec_nx;
                min        <= min_nx;
                hour_q     <= hour_nx;
                o_sec_tick <= 1'b1;
                if (day_inc)
                    o_day <= o_day + P_DAY_BIT'(1);
                o_alarm <= i_alarm_en
                         & (sec_nx == '0)
                         & (min_nx == i_alarm_min)
                         & (hour_nx == i_alarm_hour);
            end
        end
    end

endmodule

// File: tb/tb_clock_rtc_ctrl.sv
// Bench for clock_rtc_ctrl: directed scenarios plus randomized run
// against a seconds-of-day reference model.
module tb_clock_rtc_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        en;
    logic [29:0] i_freq;
    logic        i_mode_12h;
    logic        i_set_valid;
    logic        o_set_ready;
    logic [5:0]  i_set_sec;
    logic [5:0]  i_set_min;
    logic [4:0]  i_set_hour;
    logic        o_set_err;
    logic        i_alarm_en;
    logic [5:0]  i_alarm_min;
    logic [4:0]  i_alarm_hour;
    logic [5:0]  sec;
    logic [5:0]  min;
    logic [4:0]  hour;
    logic        o_pm;
    logic [15:0] o_day;
    logic        o_sec_tick;
    logic        o_alarm;

    clock_rtc_ctrl dut (
        .clk(clk), .reset(reset), .en(en), .i_freq(i_freq),
        .i_mode_12h(i_mode_12h), .i_set_valid(i_set_valid),
        .o_set_ready(o_set_ready), .i_set_sec(i_set_sec),
        .i_set_min(i_set_min), .i_set_hour(i_set_hour),
        .o_set_err(o_set_err), .i_alarm_en(i_alarm_en),
        .i_alarm_min(i_alarm_min), .i_alarm_hour(i_alarm_hour),
        .sec(sec), .min(min), .hour(hour), .o_pm(o_pm),
        .o_day(o_day), .o_sec_tick(o_sec_tick), .o_alarm(o_alarm)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // reference model: time as seconds of day
    int m_cnt, m_tod, m_day;
    bit m_tick, m_alarm, m_err, m_apply;

    task automatic model_reset();
        m_cnt = 0; m_tod = 0; m_day = 0;
        m_tick = 0; m_alarm = 0; m_err = 0; m_apply = 0;
    endtask

    function automatic logic [4:0] disp(int h, bit m12);
        if (!m12) return 5'(h);
        return 5'(((h + 11) % 12) + 1);
    endfunction

    task automatic step();
        bit acc, ok, fire;
        int eff, at;
        @(posedge clk);
        if (reset) begin
            model_reset();
        end else begin
            eff  = (i_freq <= 1) ? 1 : int'(i_freq);
            acc  = i_set_valid && !m_apply;
            ok   = (i_set_sec < 60) && (i_set_min < 60) && (i_set_hour < 24);
            fire = en && (m_cnt + 1 >= eff);
            m_err = acc && !ok;
            m_apply = acc;
            m_tick = 0;
            m_alarm = 0;
            if (acc && ok) begin
                m_tod = int'(i_set_hour) * 3600 + int'(i_set_min) * 60
                      + int'(i_set_sec);
                m_cnt = 0;
            end else if (en) begin
                if (fire) begin
                    m_cnt = 0;
                    m_tod = (m_tod + 1) % 86400;
                    if (m_tod == 0) m_day = (m_day + 1) % 65536;
                    m_tick = 1;
                    at = int'(i_alarm_hour) * 3600 + int'(i_alarm_min) * 60;
                    m_alarm = i_alarm_en && (i_alarm_min < 60)
                            && (i_alarm_hour < 24) && (m_tod == at);
                end else begin
                    m_cnt++;
                end
            end
        end
        #1;
    endtask

    task automatic do_set(int s, int m, int h);
        if (m_apply) step();
        i_set_sec   = 6'(s);
        i_set_min   = 6'(m);
        i_set_hour  = 5'(h);
        i_set_valid = 1'b1;
        step();
        i_set_valid = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; en = 1'b1; i_freq = 30'd4; i_mode_12h = 1'b0;
        i_set_valid = 1'b0; i_set_sec = '0; i_set_min = '0; i_set_hour = '0;
        i_alarm_en = 1'b0; i_alarm_min = '0; i_alarm_hour = '0;
        model_reset();
        #1;
        n_cmp++;
        if ({sec, min, hour, o_pm, o_day, o_sec_tick, o_alarm, o_set_err,
             o_set_ready} !== '0) begin
            n_bad++;
            $display("FAIL reset_outputs: got %h/%h/%h pm=%b day=%h rdy=%b want all 0",
                     sec, min, hour, o_pm, o_day, o_set_ready);
        end
        i_mode_12h = 1'b1;
        #1;
        n_cmp++;
        if (hour !== 5'd12 || o_pm !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_hour12: got %0d pm=%b want 12 pm=0", hour, o_pm);
        end
        i_mode_12h = 1'b0;
        step();
        step();
        reset = 1'b0;
        #1;
        n_cmp++;
        if (o_set_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL ready_after_reset: got %b want 1", o_set_ready);
        end
    endtask

    task automatic test_tick_rate();
        int nt = 0;
        for (int i = 0; i < 240; i++) begin
            step();
            if (o_sec_tick) nt++;
            n_cmp++;
            if (o_sec_tick !== m_tick) begin
                n_bad++;
                $display("FAIL tick_rate cyc %0d: got %b want %b", i, o_sec_tick, m_tick);
            end
        end
        n_cmp++;
        if (nt != 60 || sec !== 6'd0 || min !== 6'd1 || hour !== 5'd0) begin
            n_bad++;
            $display("FAIL tick_count: got %0d ticks %0d:%0d:%0d want 60 ticks 0:1:0",
                     nt, hour, min, sec);
        end
    endtask

    task automatic test_rollover();
        i_freq = 30'd2;
        do_set(58, 59, 23);
        n_cmp++;
        if (o_set_ready !== 1'b0 || sec !== 6'd58 || min !== 6'd59 || hour !== 5'd23) begin
            n_bad++;
            $display("FAIL set_load: got rdy=%b %0d:%0d:%0d want rdy=0 23:59:58",
                     o_set_ready, hour, min, sec);
        end
        step();
        n_cmp++;
        if (o_set_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL ready_relow: got %b want 1", o_set_ready);
        end
        repeat (3) step();
        n_cmp++;
        if ({hour, min, sec} !== '0 || o_day !== 16'd1 || o_sec_tick !== 1'b1) begin
            n_bad++;
            $display("FAIL rollover: got %0d:%0d:%0d day=%0d tick=%b want 0:0:0 day=1 tick=1",
                     hour, min, sec, o_day, o_sec_tick);
        end
    endtask

    task automatic test_set_err();
        int vals[2][3] = '{'{60, 10, 5}, '{10, 10, 24}};
        en = 1'b0;
        for (int k = 0; k < 2; k++) begin
            do_set(vals[k][0], vals[k][1], vals[k][2]);
            n_cmp++;
            if (o_set_err !== 1'b1 || {hour, min, sec} !== '0) begin
                n_bad++;
                $display("FAIL set_err%0d: got err=%b %0d:%0d:%0d want err=1 0:0:0",
                         k, o_set_err, hour, min, sec);
            end
            step();
            n_cmp++;
            if (o_set_err !== 1'b0) begin
                n_bad++;
                $display("FAIL set_err_pulse%0d: got %b want 0", k, o_set_err);
            end
        end
    endtask

    task automatic test_mode12();
        int hs[4] = '{0, 12, 13, 23};
        int eh[4] = '{12, 12, 1, 11};
        int ep[4] = '{0, 1, 1, 1};
        en = 1'b0;
        for (int k = 0; k < 4; k++) begin
            do_set(0, 0, hs[k]);
            i_mode_12h = 1'b1;
            #1;
            n_cmp++;
            if (int'(hour) != eh[k] || int'(o_pm) != ep[k]) begin
                n_bad++;
                $display("FAIL mode12 h=%0d: got %0d pm=%b want %0d pm=%0d",
                         hs[k], hour, o_pm, eh[k], ep[k]);
            end
            i_mode_12h = 1'b0;
        end
    endtask

    task automatic test_alarm();
        i_alarm_en = 1'b1; i_alarm_min = 6'd30; i_alarm_hour = 5'd7;
        i_freq = 30'd2;
        en = 1'b0;
        do_set(59, 29, 7);
        en = 1'b1;
        for (int i = 0; i < 6; i++) begin
            step();
            n_cmp++;
            if (o_alarm !== (i == 1)) begin
                n_bad++;
                $display("FAIL alarm_fire cyc %0d: got %b want %b", i, o_alarm, i == 1);
            end
        end
        do_set(0, 30, 7);
        for (int i = 0; i < 4; i++) begin
            n_cmp++;
            if (o_alarm !== 1'b0) begin
                n_bad++;
                $display("FAIL alarm_on_set cyc %0d: got %b want 0", i, o_alarm);
            end
            step();
        end
        i_alarm_en = 1'b0;
        do_set(59, 29, 7);
        for (int i = 0; i < 4; i++) begin
            step();
            n_cmp++;
            if (o_alarm !== 1'b0) begin
                n_bad++;
                $display("FAIL alarm_disabled cyc %0d: got %b want 0", i, o_alarm);
            end
        end
        n_cmp++;
        if (min !== 6'd30 || sec !== 6'd1) begin
            n_bad++;
            $display("FAIL alarm_time: got %0d:%0d want 30:1", min, sec);
        end
    endtask

    task automatic test_coincident();
        i_freq = 30'd3;
        en = 1'b1;
        do_set(0, 0, 1);
        step();
        step();
        do_set(30, 20, 10);
        n_cmp++;
        if (o_sec_tick !== 1'b0 || sec !== 6'd30 || min !== 6'd20 || hour !== 5'd10) begin
            n_bad++;
            $display("FAIL set_vs_tick: got tick=%b %0d:%0d:%0d want tick=0 10:20:30",
                     o_sec_tick, hour, min, sec);
        end
        en = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step();
            n_cmp++;
            if ({o_sec_tick, hour, min, sec} !== {1'b0, 5'd10, 6'd20, 6'd30}) begin
                n_bad++;
                $display("FAIL en_hold cyc %0d: got tick=%b %0d:%0d:%0d want 10:20:30",
                         i, o_sec_tick, hour, min, sec);
            end
        end
        en = 1'b1;
        step();
        #2;
        reset = 1'b1;
        #1;
        n_cmp++;
        if ({sec, min, hour, o_pm, o_day, o_sec_tick, o_alarm, o_set_err,
             o_set_ready} !== '0) begin
            n_bad++;
            $display("FAIL mid_reset: got %0d:%0d:%0d day=%0d rdy=%b want all 0",
                     hour, min, sec, o_day, o_set_ready);
        end
        step();
        reset = 1'b0;
    endtask

    task automatic test_random();
        logic [36:0] got, exp;
        int h, am;
        for (int i = 0; i < 3000; i++) begin
            reset = ($urandom_range(0, 499) == 0);
            en = ($urandom_range(0, 99) < 85);
            if ($urandom_range(0, 49) == 0) i_freq = 30'($urandom_range(0, 4));
            i_mode_12h = 1'($urandom_range(0, 1));
            i_set_valid = ($urandom_range(0, 9) == 0);
            i_set_sec = 6'($urandom_range(50, 61));
            i_set_min = 6'($urandom_range(0, 60));
            i_set_hour = 5'($urandom_range(0, 24));
            if ($urandom_range(0, 19) == 0) begin
                i_alarm_en = ($urandom_range(0, 3) != 0);
                if ($urandom_range(0, 3) != 0) begin
                    am = (m_tod / 60 + 1) % 1440;
                    i_alarm_hour = 5'(am / 60);
                    i_alarm_min = 6'(am % 60);
                end else begin
                    i_alarm_hour = 5'($urandom_range(0, 31));
                    i_alarm_min = 6'($urandom_range(0, 63));
                end
            end
            step();
            h = m_tod / 3600;
            got = {sec, min, hour, o_pm, o_day, o_sec_tick, o_alarm,
                   o_set_err, o_set_ready};
            exp = {6'(m_tod % 60), 6'((m_tod / 60) % 60), disp(h, i_mode_12h),
                   h >= 12, 16'(m_day), m_tick, m_alarm, m_err,
                   !m_apply && !reset};
            n_cmp++;
            if (got !== exp) begin
                n_bad++;
                $display("FAIL random cyc %0d: got %h want %h", i, got, exp);
            end
        end
        reset = 1'b0;
        i_set_valid = 1'b0;
    endtask

    initial begin
        test_reset();
        test_tick_rate();
        test_rollover();
        test_set_err();
        test_mode12();
        test_alarm();
        test_coincident();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog expired");
    end

endmodule
